// File: rtl/mux_n_skid_if.sv
// Handshake bundle for mux_n_skid: upstream word/select offer, downstream
// registered result, and the squash control.
interface mux_n_skid_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, out_err, out_valid
  );

  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, out_err, out_valid
  );
endinterface

// File: rtl/mux_n_skid.sv
// N:1 word selector with registered output and a 2-entry skid buffer
// (main register M drives the outputs, skid register S absorbs one stall).
module mux_n_skid #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input logic            clk,
  input logic            rst,
  mux_n_skid_if.slave    bus
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
    logic             valid;
  } entry_t;

  entry_t m_q;
  entry_t s_q;
  entry_t new_entry;
  logic   accept;
  logic   m_free;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    new_entry       = '0;
    new_entry.sel   = bus.in_sel;
    new_entry.err   = 1'b1;
    new_entry.valid = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        new_entry.data = bus.in_data[k*WIDTH +: WIDTH];
        new_entry.err  = 1'b0;
      end
    end
  end

  // in_ready depends on registered state only, never on out_ready.
  assign bus.in_ready = ~s_q.valid;
  assign accept       = bus.in_valid & ~s_q.valid;
  assign m_free       = ~m_q.valid | bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
      s_q <= '0;
    end else if (flush_q_n()) begin
      m_q.valid <= 1'b0;
      s_q.valid <= 1'b0;
    end else if (m_free) begin
      if (s_q.valid) begin
        // S only fills while M is held, so it is always the older word.
        m_q       <= s_q;
        s_q.valid <= 1'b0;
      end else if (accept) begin
        m_q <= new_entry;
      end else begin
        m_q.valid <= 1'b0;
      end
    end else if (accept) begin
      s_q <= new_entry;
    end
  end

  function automatic logic flush_q_n();
    return bus.flush;
  endfunction

  assign bus.out_data  = m_q.data;
  assign bus.out_sel   = m_q.sel;
  assign bus.out_err   = m_q.err;
  assign bus.out_valid = m_q.valid;

endmodule

// File: tb/tb_mux_n_skid.sv
// Drives a 4-input and a 3-input mux_n_skid with identical handshakes and
// compares both against a FIFO-occupancy queue model.
module tb_mux_n_skid;
  localparam int WIDTH = 32;
  localparam int SEL_W = 2;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } word_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             out_ready;
  logic [SEL_W-1:0] in_sel;
  logic [WIDTH-1:0] words [4];

  int n_vec  = 0;
  int n_fail = 0;

  word_t q4[$];
  word_t q3[$];

  mux_n_skid_if #(.WIDTH(WIDTH), .NUM_IN(4), .SEL_W(SEL_W)) bus4 ();
  mux_n_skid_if #(.WIDTH(WIDTH), .NUM_IN(3), .SEL_W(SEL_W)) bus3 ();

  assign bus4.in_data   = {words[3], words[2], words[1], words[0]};
  assign bus3.in_data   = {words[2], words[1], words[0]};
  assign bus4.in_sel    = in_sel;
  assign bus3.in_sel    = in_sel;
  assign bus4.in_valid  = in_valid;
  assign bus3.in_valid  = in_valid;
  assign bus4.flush     = flush;
  assign bus3.flush     = flush;
  assign bus4.out_ready = out_ready;
  assign bus3.out_ready = out_ready;

  mux_n_skid #(.WIDTH(WIDTH), .NUM_IN(4), .SEL_W(SEL_W)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );
  mux_n_skid #(.WIDTH(WIDTH), .NUM_IN(3), .SEL_W(SEL_W)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  always #5 clk = ~clk;

  function automatic word_t pick(int n);
    word_t w;
    w.sel = in_sel;
    if (int'(in_sel) < n) begin
      w.data = words[in_sel];
      w.err  = 1'b0;
    end else begin
      w.data = '0;
      w.err  = 1'b1;
    end
    return w;
  endfunction

  // One clock: the model applies the same inputs the DUTs sample at the edge,
  // then outputs are inspected 1 time unit later.
  task automatic tick();
    word_t w4, w3;
    bit    acc, con;
    w4  = pick(4);
    w3  = pick(3);
    acc = in_valid && (q4.size() < 2);
    con = out_ready && (q4.size() > 0);
    @(posedge clk);
    if (rst || flush) begin
      q4.delete();
      q3.delete();
    end else begin
      if (con) begin
        void'(q4.pop_front());
        void'(q3.pop_front());
      end
      if (acc) begin
        q4.push_back(w4);
        q3.push_back(w3);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sel = '0;
    for (int i = 0; i < 4; i++) words[i] = 32'hdead_0000 + i;
    tick();
    tick();
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      n_vec++;
      if ({bus4.out_valid, bus4.out_data, bus4.out_sel, bus4.out_err, bus4.in_ready} !== {1'b0, 32'h0, 2'd0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL reset4[%0d]: got v=%0b d=%h s=%0d e=%0b r=%0b want v=0 d=0 s=0 e=0 r=1", r,
                 bus4.out_valid, bus4.out_data, bus4.out_sel, bus4.out_err, bus4.in_ready);
      end
      n_vec++;
      if ({bus3.out_valid, bus3.out_data, bus3.out_sel, bus3.out_err, bus3.in_ready} !== {1'b0, 32'h0, 2'd0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL reset3[%0d]: got v=%0b d=%h s=%0d e=%0b r=%0b want v=0 d=0 s=0 e=0 r=1", r,
                 bus3.out_valid, bus3.out_data, bus3.out_sel, bus3.out_err, bus3.in_ready);
      end
      tick();
    end
  endtask

  task automatic set_fixed_words();
    words[0] = 32'h1111_1111; words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333; words[3] = 32'h4444_4444;
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] exp3;
    set_fixed_words();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel = SEL_W'(i);
      tick();
      n_vec++;
      if ({bus4.out_valid, bus4.out_data, bus4.out_sel, bus4.out_err} !== {1'b1, 32'h1111_1111 * (i + 1), SEL_W'(i), 1'b0}) begin
        n_fail++;
        $display("FAIL stream4[%0d]: got v=%0b d=%h s=%0d e=%0b want v=1 d=%h s=%0d e=0", i,
                 bus4.out_valid, bus4.out_data, bus4.out_sel, bus4.out_err, 32'h1111_1111 * (i + 1), i);
      end
      exp3 = (i < 3) ? 32'h1111_1111 * (i + 1) : 32'h0;
      n_vec++;
      if ({bus3.out_valid, bus3.out_data, bus3.out_err} !== {1'b1, exp3, i == 3}) begin
        n_fail++;
        $display("FAIL stream3[%0d]: got v=%0b d=%h e=%0b want v=1 d=%h e=%0b", i,
                 bus3.out_valid, bus3.out_data, bus3.out_err, exp3, i == 3);
      end
    end
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (bus4.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: got out_valid=%0b want 0", bus4.out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] exp_d [5];
    logic             exp_r [5];
    logic             exp_v [5];
    exp_d = '{32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 32'h3333_3333, 32'h0};
    exp_r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    set_fixed_words();
    for (int i = 0; i < 5; i++) begin
      in_valid  = (i < 3);
      in_sel    = (i == 0) ? 2'd1 : (i == 1) ? 2'd2 : 2'd3;
      out_ready = (i >= 3);
      tick();
      n_vec++;
      if ({bus4.out_valid, bus4.in_ready} !== {exp_v[i], exp_r[i]} ||
          (exp_v[i] && bus4.out_data !== exp_d[i])) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got v=%0b r=%0b d=%h want v=%0b r=%0b d=%h", i,
                 bus4.out_valid, bus4.in_ready, bus4.out_data, exp_v[i], exp_r[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    set_fixed_words();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    tick();
    n_vec++;
    if ({bus3.out_valid, bus3.out_data, bus3.out_sel, bus3.out_err} !== {1'b1, 32'h0, 2'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL oor_err: got v=%0b d=%h s=%0d e=%0b want v=1 d=0 s=3 e=1",
               bus3.out_valid, bus3.out_data, bus3.out_sel, bus3.out_err);
    end
    in_sel = 2'd0;
    tick();
    n_vec++;
    if ({bus3.out_valid, bus3.out_data, bus3.out_sel, bus3.out_err} !== {1'b1, 32'h1111_1111, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL oor_next: got v=%0b d=%h s=%0d e=%0b want v=1 d=11111111 s=0 e=0",
               bus3.out_valid, bus3.out_data, bus3.out_sel, bus3.out_err);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    set_fixed_words();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    tick();
    in_sel = 2'd1;
    tick();
    n_vec++;
    if ({bus4.out_valid, bus4.in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_full: got v=%0b r=%0b want v=1 r=0", bus4.out_valid, bus4.in_ready);
    end
    in_sel = 2'd2;
    flush  = 1'b1;
    tick();
    n_vec++;
    if ({bus4.out_valid, bus4.in_ready, bus3.out_valid, bus3.in_ready} !== 4'b0101) begin
      n_fail++;
      $display("FAIL flush: got v4=%0b r4=%0b v3=%0b r3=%0b want v=0 r=1",
               bus4.out_valid, bus4.in_ready, bus3.out_valid, bus3.in_ready);
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (bus4.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_ghost[%0d]: got out_valid=%0b d=%h want out_valid=0", i,
                 bus4.out_valid, bus4.out_data);
      end
    end
  endtask

  task automatic test_random();
    logic [36:0] obs, exp;
    logic [34:0] prev4;
    bit          stalled;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) words[i] = $urandom;
      in_sel    = SEL_W'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      stalled   = bus4.out_valid && !out_ready && !flush;
      prev4     = {bus4.out_data, bus4.out_sel, bus4.out_err};
      tick();
      obs = {bus4.out_valid, bus4.in_ready, bus4.out_valid ? {bus4.out_data, bus4.out_sel, bus4.out_err} : 35'b0};
      exp = {q4.size() > 0, q4.size() < 2, (q4.size() > 0) ? {q4[0].data, q4[0].sel, q4[0].err} : 35'b0};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random4 cycle %0d: got %h want %h", c, obs, exp);
      end
      obs = {bus3.out_valid, bus3.in_ready, bus3.out_valid ? {bus3.out_data, bus3.out_sel, bus3.out_err} : 35'b0};
      exp = {q3.size() > 0, q3.size() < 2, (q3.size() > 0) ? {q3[0].data, q3[0].sel, q3[0].err} : 35'b0};
      n_vec++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random3 cycle %0d: got %h want %h", c, obs, exp);
      end
      if (stalled) begin
        n_vec++;
        if ({bus4.out_data, bus4.out_sel, bus4.out_err} !== prev4) begin
          n_fail++;
          $display("FAIL stall_stable cycle %0d: got %h want %h", c,
                   {bus4.out_data, bus4.out_sel, bus4.out_err}, prev4);
        end
      end
    end
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_out_of_range();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_n_skid.md
Name: mux_n_skid

Overview:
- Parametrised N:1 word selector with a registered output and a valid/ready handshake on both sides.
- Inserted between pipeline stages of the RISC-V core, e.g. operand/forwarding select feeding the EX stage.
- A 2-entry skid buffer lets upstream keep full throughput while downstream stalls.
- Adds out-of-range select detection and a flush input for branch/trap squashing.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- NUM_IN, 4, number of selectable inputs (>=2).
- SEL_W, 2, select width. Must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  index of the input to capture.
- in_valid  input  1  upstream offers {in_data, in_sel} this cycle.
- in_ready  output  1  block can accept this cycle.
- flush  input  1  discard all buffered words.
- out_data  output  WIDTH  selected word, registered.
- out_sel  output  SEL_W  select value that produced out_data.
- out_err  output  1  in_sel was >= NUM_IN for this word.
- out_valid  output  1  out_data/out_sel/out_err are valid.
- out_ready  input  1  downstream consumes when high with out_valid.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. All state changes on rising clk edge.
- Storage: main register M (drives outputs) and skid register S. Each entry holds {data, sel, err, valid}.
- in_ready = ~S.valid. This is a registered-state function only, with no combinational path from out_ready.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Selection on accept:
  - in_sel < NUM_IN: data = in_data word in_sel, err = 0.
  - in_sel >= NUM_IN: data = 0, err = 1.
  - sel is stored unchanged in both cases.
- Latency: an accepted word appears on the outputs the next cycle if M is empty or being consumed. Throughput is 1 word/cycle when out_ready is held high.
- Next-state rules, evaluated in order:
  - rst: M.valid = S.valid = 0. out_data = 0, out_sel = 0, out_err = 0. in_ready = 1 in the cycle after reset.
  - flush: M.valid = S.valid = 0. Any same-cycle accept is dropped. Flush overrides accept and consume. The data fields may be left unchanged, but out_valid = 0 next cycle.
  - Otherwise, M empty or consumed:
    - S valid: M <- S, S cleared. If an accept also occurs, the new word goes to S.
    - S empty, accept: M <- new word.
    - S empty, no accept: M.valid = 0.
  - Otherwise, M held (out_valid & ~out_ready):
    - Accept loads S (only possible when S empty).
    - M is unchanged.
- Stability: while out_valid=1 and out_ready=0, out_data, out_sel and out_err hold constant.
- Ordering: strict FIFO. No word is duplicated or lost except by flush or rst.
- When out_valid=0, the out_data value is don't-care for consumers. The bench checks it only after reset.
- rst asserted mid-transfer: same as the rst rule. Pending words are lost, and out_valid=0 the next cycle.
- Purely synchronous RTL. No latches; every case has a default assignment.

Test Plan:
- Reset: assert rst 2 cycles, then release -> out_valid=0, out_data=0, out_err=0, in_ready=1.
- Streaming (NUM_IN=4, WIDTH=32): inputs 0x11111111/0x22222222/0x33333333/0x44444444, out_ready=1, in_sel=0,1,2,3 on consecutive cycles -> out_data 0x11111111..0x44444444 one cycle later each, back-to-back, out_sel matches.
- Backpressure: out_ready=0 while sending sel=1 then sel=2 -> M holds 0x22222222 stable, S takes 0x33333333, in_ready=0. Raise out_ready -> 0x22222222 then 0x33333333 delivered, in_ready returns 1.
- Out-of-range (NUM_IN=3, SEL_W=2): in_sel=3 -> out_data=0, out_err=1, out_sel=3. Next word sel=0 -> out_err=0.
- Flush with both entries full, plus in_valid=1 the same cycle -> next cycle out_valid=0, in_ready=1. The flushed and same-cycle words never appear.
- Random: 10k cycles with random in_valid/out_ready/in_sel, checked against a queue model -> order, data and err match, and out_data is stable under stall.
